// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch path.
// Holds the fetch FSM encoding and the fixed instruction geometry.
// No logic here; imported by the fetch sequencer and its next-PC mux.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  // Bytes per instruction; sequential fetch advances the PC by this much.
  localparam logic [31:0] INSTR_BYTES     = 32'd4;
  // Address bits that must be zero for a word-aligned fetch target.
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;
  // Instruction word held in INSTR while nothing has been fetched yet.
  localparam logic [31:0] NOP             = 32'h0000_0000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, control/decode and instruction memory.
// master = fetch sequencer side, slave = environment (decode + memory).
// Pure wiring; no state.
interface fetch_sequencer_if;

  logic        PC_SEL;
  logic [31:0] JUMP;
  logic        BRANCH_TAKEN;
  logic [31:0] BRANCH_TGT;
  logic        STALL;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_ACK;
  logic [31:0] IMEM_RDATA;
  logic [31:0] INSTR;
  logic        INSTR_VALID;
  logic [31:0] PC_OUT;
  logic        FAULT;

  modport master (
    input  PC_SEL, JUMP, BRANCH_TAKEN, BRANCH_TGT, STALL, IMEM_ACK, IMEM_RDATA,
    output IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID, PC_OUT, FAULT
  );

  modport slave (
    output PC_SEL, JUMP, BRANCH_TAKEN, BRANCH_TGT, STALL, IMEM_ACK, IMEM_RDATA,
    input  IMEM_REQ, IMEM_ADDR, INSTR, INSTR_VALID, PC_OUT, FAULT
  );

endinterface

// File: rtl/next_pc_sel.sv
// Next-PC selection: jump over branch over sequential, plus alignment check.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module next_pc_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic        pc_sel_i,
  input  logic [31:0] jump_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_tgt_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  // Priority mux; the sequential add wraps naturally at 2^32.
  always_comb begin
    next_pc_o = pc_i + INSTR_BYTES;
    if (pc_sel_i) begin
      next_pc_o = jump_i;
    end else if (branch_taken_i) begin
      next_pc_o = branch_tgt_i;
    end
    misaligned_o = |(next_pc_o[1:0] & WORD_ALIGN_MASK);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC: boot hold, handshaked imem fetch, issue, next-PC and fault.
// Latency: best case one instruction every 2 cycles (ACK in first FETCH cycle).
// Backpressure: STALL holds ISSUE indefinitely; missing ACK times out to FAULT.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_HOLD    = 4,
  parameter int unsigned MEM_TIMEOUT  = 15
) (
  input  logic               CLK,
  input  logic               RST,
  fetch_sequencer_if.master  bus
);

  localparam logic [1:0] S_BOOT  = BOOT;
  localparam logic [1:0] S_FETCH = FETCH;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_FAULT = FAULT;

  // Last boot count before the first fetch, and the FETCH wait limit.
  localparam logic [3:0] BOOT_LAST = 4'(BOOT_HOLD - 1);
  localparam logic [7:0] TO_LIMIT  = 8'(MEM_TIMEOUT);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [7:0]  to_cnt_q, to_cnt_d;

  logic [31:0] next_pc;
  logic        misaligned;

  next_pc_sel u_next_pc_sel (
    .pc_i           (pc_q),
    .pc_sel_i       (bus.PC_SEL),
    .jump_i         (bus.JUMP),
    .branch_taken_i (bus.BRANCH_TAKEN),
    .branch_tgt_i   (bus.BRANCH_TGT),
    .next_pc_o      (next_pc),
    .misaligned_o   (misaligned)
  );

  // FSM next-state: every output is a register, so all decisions land here.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    boot_cnt_d = boot_cnt_q;
    to_cnt_d   = to_cnt_q;

    case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = S_FETCH;
          req_d      = 1'b1;
          boot_cnt_d = '0;
          to_cnt_d   = '0;
        end else begin
          boot_cnt_d = boot_cnt_q + 4'd1;
        end
      end

      S_FETCH: begin
        if (bus.IMEM_ACK) begin
          state_d = S_ISSUE;
          instr_d = bus.IMEM_RDATA;
          valid_d = 1'b1;
          req_d   = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
          if (to_cnt_d == TO_LIMIT) begin
            state_d = S_FAULT;
            req_d   = 1'b0;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        // While stalled nothing moves and the redirect inputs are ignored.
        if (!bus.STALL) begin
          if (misaligned) begin
            state_d = S_FAULT;
            req_d   = 1'b0;
            valid_d = 1'b0;
            fault_d = 1'b1;
          end else begin
            state_d  = S_FETCH;
            pc_d     = next_pc;
            req_d    = 1'b1;
            valid_d  = 1'b0;
            to_cnt_d = '0;
          end
        end
      end

      default: begin
        // FAULT is terminal until reset.
        state_d = S_FAULT;
        req_d   = 1'b0;
        valid_d = 1'b0;
        fault_d = 1'b1;
      end
    endcase
  end

  // State registers; reset overrides everything, abandoning any open request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_BOOT;
      pc_q       <= RESET_VECTOR;
      req_q      <= 1'b0;
      instr_q    <= NOP;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      boot_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      boot_cnt_q <= boot_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign bus.IMEM_REQ    = req_q;
  assign bus.IMEM_ADDR   = pc_q;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_VALID = valid_q;
  assign bus.PC_OUT      = pc_q;
  assign bus.FAULT       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: cycle table plus reset/timeout/wrap sequences.
module tb_fetch_sequencer;

  logic CLK = 1'b0;
  logic RST;
  logic RST2;

  always #5 CLK = ~CLK;

  fetch_sequencer_if bus ();
  fetch_sequencer_if bus2 ();

  fetch_sequencer #(
    .RESET_VECTOR (32'h0000_0000),
    .BOOT_HOLD    (4),
    .MEM_TIMEOUT  (15)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  fetch_sequencer #(
    .RESET_VECTOR (32'hFFFF_FFFC),
    .BOOT_HOLD    (4),
    .MEM_TIMEOUT  (15)
  ) dut2 (
    .CLK (CLK),
    .RST (RST2),
    .bus (bus2)
  );

  typedef struct {
    logic        stall;
    logic        pc_sel;
    logic        br;
    logic        ack;
    logic [31:0] jump;
    logic [31:0] btgt;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  vec_t vq[$];
  int   tests  = 0;
  int   failed = 0;
  int   wait_cycles;

  localparam logic [31:0] JUNK = 32'hEEEE_EEEE;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic v(input logic s, input logic p, input logic b, input logic a,
                   input logic [31:0] j, input logic [31:0] t, input logic [31:0] rd,
                   input logic er, input logic [31:0] ep, input logic ev,
                   input logic [31:0] ei, input logic ef);
    vec_t r;
    r.stall = s; r.pc_sel = p; r.br = b; r.ack = a;
    r.jump = j; r.btgt = t; r.rdata = rd;
    r.e_req = er; r.e_pc = ep; r.e_valid = ev; r.e_instr = ei; r.e_fault = ef;
    vq.push_back(r);
  endtask

  task automatic drive(input logic s, input logic p, input logic b, input logic a,
                       input logic [31:0] j, input logic [31:0] t, input logic [31:0] rd);
    bus.STALL = s; bus.PC_SEL = p; bus.BRANCH_TAKEN = b; bus.IMEM_ACK = a;
    bus.JUMP = j; bus.BRANCH_TGT = t; bus.IMEM_RDATA = rd;
  endtask

  task automatic chk_outs(input string nm, input logic er, input logic [31:0] ep,
                          input logic ev, input logic [31:0] ei, input logic ef);
    chk({nm, ".req"},   32'(bus.IMEM_REQ),    32'(er));
    chk({nm, ".pc"},    bus.PC_OUT,           ep);
    chk({nm, ".addr"},  bus.IMEM_ADDR,        ep);
    chk({nm, ".valid"}, 32'(bus.INSTR_VALID), 32'(ev));
    chk({nm, ".instr"}, bus.INSTR,            ei);
    chk({nm, ".fault"}, 32'(bus.FAULT),       ef);
  endtask

  initial begin
    RST  = 1'b1;
    RST2 = 1'b1;
    drive(0, 0, 0, 1, 32'd0, 32'd0, JUNK);
    bus2.STALL = 1'b0; bus2.PC_SEL = 1'b0; bus2.BRANCH_TAKEN = 1'b0;
    bus2.IMEM_ACK = 1'b1; bus2.JUMP = 32'd0; bus2.BRANCH_TGT = 32'd0;
    bus2.IMEM_RDATA = 32'hCAFE_0001;

    // ---- PC wrap at top of address space (second instance) ----
    tick();
    chk("wrap.reset_pc", bus2.PC_OUT, 32'hFFFF_FFFC);
    RST2 = 1'b0;
    repeat (4) tick();
    chk("wrap.req", 32'(bus2.IMEM_REQ), 32'd1);
    chk("wrap.addr", bus2.IMEM_ADDR, 32'hFFFF_FFFC);
    tick();
    chk("wrap.valid", 32'(bus2.INSTR_VALID), 32'd1);
    chk("wrap.instr", bus2.INSTR, 32'hCAFE_0001);
    tick();
    chk("wrap.next_pc", bus2.PC_OUT, 32'h0000_0000);
    chk("wrap.req2", 32'(bus2.IMEM_REQ), 32'd1);
    RST2 = 1'b1;

    // ---- Main table: boot, fetch loop, jump/branch, mem wait, stall, misalign ----
    //  s p b a  jump     btgt     rdata            req pc        v  instr          f
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            0, 32'd0,   0, 32'h0,         0);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            0, 32'd0,   0, 32'h0,         0);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            0, 32'd0,   0, 32'h0,         0);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            1, 32'd0,   0, 32'h0,         0);
    v(0,0,0,1, 32'd0,   32'd0,   32'h1111_0000,   0, 32'd0,   1, 32'h1111_0000, 0);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            1, 32'd4,   0, 32'h1111_0000, 0);
    v(0,0,0,1, 32'd0,   32'd0,   32'h2222_0004,   0, 32'd4,   1, 32'h2222_0004, 0);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            1, 32'd8,   0, 32'h2222_0004, 0);
    v(0,0,0,1, 32'd0,   32'd0,   32'h3333_0008,   0, 32'd8,   1, 32'h3333_0008, 0);
    v(0,1,1,1, 32'd100, 32'd200, JUNK,            1, 32'd100, 0, 32'h3333_0008, 0);
    v(0,0,0,1, 32'd0,   32'd0,   32'h4444_0064,   0, 32'd100, 1, 32'h4444_0064, 0);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            1, 32'd104, 0, 32'h4444_0064, 0);
    v(0,0,0,1, 32'd0,   32'd0,   32'h5555_0068,   0, 32'd104, 1, 32'h5555_0068, 0);
    v(0,0,1,1, 32'd0,   32'd200, JUNK,            1, 32'd200, 0, 32'h5555_0068, 0);
    v(0,0,0,0, 32'd0,   32'd0,   JUNK,            1, 32'd200, 0, 32'h5555_0068, 0);
    v(0,0,0,0, 32'd0,   32'd0,   JUNK,            1, 32'd200, 0, 32'h5555_0068, 0);
    v(0,0,0,0, 32'd0,   32'd0,   JUNK,            1, 32'd200, 0, 32'h5555_0068, 0);
    v(0,0,0,1, 32'd0,   32'd0,   32'h6666_00C8,   0, 32'd200, 1, 32'h6666_00C8, 0);
    v(1,1,0,1, 32'd300, 32'd0,   JUNK,            0, 32'd200, 1, 32'h6666_00C8, 0);
    v(1,0,0,1, 32'd300, 32'd0,   JUNK,            0, 32'd200, 1, 32'h6666_00C8, 0);
    v(1,1,0,1, 32'd300, 32'd0,   JUNK,            0, 32'd200, 1, 32'h6666_00C8, 0);
    v(1,0,1,1, 32'd0,   32'd400, JUNK,            0, 32'd200, 1, 32'h6666_00C8, 0);
    v(1,1,0,1, 32'd300, 32'd0,   JUNK,            0, 32'd200, 1, 32'h6666_00C8, 0);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            1, 32'd204, 0, 32'h6666_00C8, 0);
    v(0,0,0,1, 32'd0,   32'd0,   32'h7777_00CC,   0, 32'd204, 1, 32'h7777_00CC, 0);
    v(0,1,0,1, 32'd102, 32'd0,   JUNK,            0, 32'd204, 0, 32'h7777_00CC, 1);
    v(0,0,0,1, 32'd0,   32'd0,   JUNK,            0, 32'd204, 0, 32'h7777_00CC, 1);

    tick();
    chk_outs("reset", 0, 32'd0, 0, 32'h0, 0);
    RST = 1'b0;
    foreach (vq[i]) begin
      drive(vq[i].stall, vq[i].pc_sel, vq[i].br, vq[i].ack,
            vq[i].jump, vq[i].btgt, vq[i].rdata);
      tick();
      chk_outs($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_pc,
               vq[i].e_valid, vq[i].e_instr, vq[i].e_fault);
    end

    // ---- Reset held several cycles, then boot length measured ----
    drive(0, 0, 0, 1, 32'd0, 32'd0, 32'h1234_5678);
    RST = 1'b1;
    repeat (3) tick();
    chk_outs("rst_held", 0, 32'd0, 0, 32'h0, 0);
    RST = 1'b0;
    wait_cycles = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus.IMEM_REQ === 1'b1) begin
        wait_cycles = i;
        break;
      end
    end
    chk("boot_len", 32'(wait_cycles), 32'd4);

    // ---- Reset while a fetch is outstanding ----
    tick();
    chk("mid.instr_pre", bus.INSTR, 32'h1234_5678);
    tick();
    chk("mid.pc_pre", bus.PC_OUT, 32'd4);
    drive(0, 0, 0, 0, 32'd0, 32'd0, 32'hDEAD_BEEF);
    tick();
    chk("mid.req_pre", 32'(bus.IMEM_REQ), 32'd1);
    RST = 1'b1;
    bus.IMEM_ACK = 1'b1;
    tick();
    chk_outs("mid.rst", 0, 32'd0, 0, 32'h0, 0);
    RST = 1'b0;
    tick();
    chk_outs("mid.late_ack", 0, 32'd0, 0, 32'h0, 0);

    // ---- Memory timeout to FAULT, then recovery through reset ----
    RST = 1'b1;
    drive(0, 0, 0, 0, 32'd0, 32'd0, JUNK);
    tick();
    RST = 1'b0;
    repeat (4) tick();
    chk("to.req_start", 32'(bus.IMEM_REQ), 32'd1);
    repeat (14) tick();
    chk_outs("to.cycle14", 1, 32'd0, 0, 32'h0, 0);
    tick();
    chk_outs("to.cycle15", 0, 32'd0, 0, 32'h0, 1);
    repeat (2) tick();
    chk_outs("to.sticky", 0, 32'd0, 0, 32'h0, 1);
    RST = 1'b1;
    tick();
    chk_outs("to.rst", 0, 32'd0, 0, 32'h0, 0);
    RST = 1'b0;
    bus.IMEM_ACK = 1'b1;
    bus.IMEM_RDATA = 32'h0BAD_F00D;
    repeat (4) tick();
    chk_outs("to.restart", 1, 32'd0, 0, 32'h0, 0);
    tick();
    chk_outs("to.refetch", 0, 32'd0, 1, 32'h0BAD_F00D, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
